feature_map_collector: RTL and testbench

- Downstream neighbour of the winograd conv/pool/ReLU core.
- Accepts the core's per-kernel one-hot result pulses and absorbs them in per-kernel FIFOs.
- Drives per-kernel hold back to the core.
- Serialises results into one ready/valid stream in pixel-major, kernel-minor order (pixel p: kernel 0..N_KERNELS-1), tagged with kernel index and pixel address, for the next layer or the memory writer.

---
 rtl/feature_map_collector_pkg.sv | 20 ++
 rtl/small_sync_fifo.sv | 57 +++++
 rtl/feature_map_collector.sv | 146 ++++++++++++++
 tb/tb_feature_map_collector.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/feature_map_collector_pkg.sv
// Shared types and helpers for the feature-map collector.
//   state_t        : output sequencer states (SCAN / SEND / DONE)
//   DEF_FIFO_DEPTH : default per-kernel FIFO depth
//   kernel_w()     : width of a kernel index (at least 1 bit)
//   addr_w()       : width of a pixel address (at least 1 bit)
package feature_map_collector_pkg;

  typedef enum logic [1:0] {SCAN, SEND, DONE} state_t;

  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int kernel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/small_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clock_i, reset_i : clock, async active-high reset (empties the FIFO)
//   push, wdata      : write strobe / data (ignored when full unless popping)
//   pop              : remove head entry (ignored when empty)
//   rdata            : head entry, valid while !empty
//   empty, full      : occupancy flags
//   count            : current occupancy, 0..DEPTH
module small_sync_fifo
  import feature_map_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/feature_map_collector.sv
// Collects per-kernel result pulses from the conv/pool/ReLU core into
// per-kernel FIFOs and serialises them pixel-major, kernel-minor onto one
// ready/valid stream tagged with kernel index and pixel address.
// Optional: define FEATURE_MAP_COLLECTOR_STALL_CNT_EN to count output stall
// cycles on stall_cycles_o (otherwise it is tied to 0).
// Ports:
//   clock_i, reset_i    : clock, async active-high reset
//   data_valid_i/data_i : per-kernel result strobe / word from the core
//   hold_data_o         : per-kernel backpressure to the core
//   out_valid_o/out_ready_i/out_data_o : output stream
//   out_kernel_o/out_addr_o : feature-map index / pixel index of the word
//   frame_done_o        : one-cycle pulse after the last word of a frame
//   overflow_o          : sticky, some write was dropped
//   stall_cycles_o      : valid-but-not-ready cycles in the current frame
module feature_map_collector
  import feature_map_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_KERNELS  = 64,
  parameter int OUT_ROWS   = 6,
  parameter int OUT_COLS   = 6,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic [N_KERNELS-1:0]                   data_valid_i,
  input  logic [N_KERNELS-1:0][DATA_WIDTH-1:0]   data_i,
  output logic [N_KERNELS-1:0]                   hold_data_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [DATA_WIDTH-1:0]                  out_data_o,
  output logic [kernel_w(N_KERNELS)-1:0]         out_kernel_o,
  output logic [addr_w(OUT_ROWS*OUT_COLS)-1:0]   out_addr_o,
  output logic                                   frame_done_o,
  output logic                                   overflow_o,
  output logic [31:0]                            stall_cycles_o
);

  localparam int KW   = kernel_w(N_KERNELS);
  localparam int NPIX = OUT_ROWS * OUT_COLS;
  localparam int AW   = addr_w(NPIX);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  state_t                               state, state_n;
  logic [KW-1:0]                        cur_k, nxt_k, take_k;
  logic [AW-1:0]                        cur_p, nxt_p;
  logic                                 wrap, last, take;
  logic [N_KERNELS-1:0]                 pop, empty, full, drop;
  logic [N_KERNELS-1:0][DATA_WIDTH-1:0] rdata;
  logic [N_KERNELS-1:0][CW-1:0]         cnt;

  for (genvar k = 0; k < N_KERNELS; k++) begin : g_fifo
    small_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push    (data_valid_i[k]),
      .pop     (pop[k]),
      .wdata   (data_i[k]),
      .rdata   (rdata[k]),
      .empty   (empty[k]),
      .full    (full[k]),
      .count   (cnt[k])
    );
    // Count is a register, so comparing it equals registering the compare
    // of its next value; the threshold leaves one slot for an in-flight strobe.
    assign hold_data_o[k] = (cnt[k] >= CW'(FIFO_DEPTH - 1));
  end

  // Pops only happen on non-empty FIFOs, so a strobe into a full,
  // non-popping FIFO is exactly a dropped word.
  assign drop  = data_valid_i & full & ~pop;

  assign wrap  = (cur_k == KW'(N_KERNELS - 1));
  assign nxt_k = wrap ? '0 : KW'(cur_k + 1'b1);
  assign nxt_p = wrap ? AW'(cur_p + 1'b1) : cur_p;
  assign last  = wrap && (cur_p == AW'(NPIX - 1));

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= SCAN;
    else         state <= state_n;
  end

  // Next-state logic; take/take_k select the FIFO to pop into the output reg
  always_comb begin
    state_n = state;
    take    = 1'b0;
    take_k  = cur_k;
    case (state)
      SCAN: if (!empty[cur_k]) begin
        take    = 1'b1;
        state_n = SEND;
      end
      SEND: if (out_ready_i) begin
        if (last) state_n = DONE;
        else if (!empty[nxt_k]) begin
          take   = 1'b1;
          take_k = nxt_k;
        end else state_n = SCAN;
      end
      DONE:    state_n = SCAN;
      default: state_n = SCAN;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid_o  = (state == SEND);
    frame_done_o = (state == DONE);
    for (int k = 0; k < N_KERNELS; k++) pop[k] = take && (take_k == KW'(k));
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cur_k      <= '0;
      cur_p      <= '0;
      out_data_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (state == SEND && out_ready_i) begin
        cur_k <= nxt_k;
        cur_p <= last ? '0 : nxt_p;
      end
      if (take)  out_data_o <= rdata[take_k];
      if (|drop) overflow_o <= 1'b1;
    end
  end

  // The tag always names the word being offered: the pointer only moves on
  // accept, in the same edge that loads the next word.
  assign out_kernel_o = cur_k;
  assign out_addr_o   = cur_p;

`ifdef FEATURE_MAP_COLLECTOR_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                                  stall_q <= '0;
    else if (state == DONE)                       stall_q <= '0;
    else if (out_valid_o && !out_ready_i && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end
  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_feature_map_collector.sv
// Directed bench for feature_map_collector (4 kernels, 2x2 pixels, depth 4).
// A queue-based model tracks the expected stream order; a negedge process
// compares every meaningful output cycle, and directed literal checks pin
// latency, hold, overflow, reset and stall behaviour.
module tb_feature_map_collector;

  localparam int NK = 4, ROWS = 2, COLS = 2, NPIX = 4, DEPTH = 4, DW = 32;
`ifdef FEATURE_MAP_COLLECTOR_STALL_CNT_EN
  localparam int STALL5 = 5;
`else
  localparam int STALL5 = 0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NK-1:0]        data_valid = '0;
  logic [NK-1:0][DW-1:0] data_in = '0;
  logic [NK-1:0]        hold;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_kernel, out_addr;
  logic                 frame_done, overflow;
  logic [31:0]          stall;

  always #5 clock = ~clock;

  feature_map_collector #(
    .DATA_WIDTH(DW), .N_KERNELS(NK), .OUT_ROWS(ROWS), .OUT_COLS(COLS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock_i(clock), .reset_i(reset), .data_valid_i(data_valid), .data_i(data_in),
    .hold_data_o(hold), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_kernel_o(out_kernel), .out_addr_o(out_addr),
    .frame_done_o(frame_done), .overflow_o(overflow), .stall_cycles_o(stall)
  );

  int errors = 0, checks = 0;

  function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- model: per-kernel queues + expected position --------------
  logic [DW-1:0] mq [NK][$];
  int  ek = 0, ep = 0;
  bit  done_pend = 0, m_ov = 0;

  always @(negedge clock) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) mq[k].delete();
      ek = 0; ep = 0; done_pend = 0; m_ov = 0;
    end else begin
      chk("m_frame_done", frame_done, done_pend);
      done_pend = 0;
      chk("m_overflow", overflow, m_ov);
      if (out_valid) begin
        if (mq[ek].size() == 0) chk("m_order_nonempty", 0, 1);
        else chk("m_data", out_data, mq[ek][0]);
        chk("m_kernel", out_kernel, ek);
        chk("m_addr", out_addr, ep);
        if (out_ready) begin
          if (mq[ek].size() != 0) void'(mq[ek].pop_front());
          ek++;
          if (ek == NK) begin
            ek = 0; ep++;
            if (ep == NPIX) begin ep = 0; done_pend = 1; end
          end
        end
      end
      // stimulus never lets a kernel's word sit in the output register
      // while its FIFO is full, so capacity is simply DEPTH here
      for (int k = 0; k < NK; k++)
        if (data_valid[k]) begin
          if (mq[k].size() < DEPTH) mq[k].push_back(data_in[k]);
          else m_ov = 1;
        end
    end
  end

  // ---------------- stimulus helpers (inputs change 2 units after posedge) ----
  task tick(); @(posedge clock); #2; endtask

  task push(input int k, input logic [DW-1:0] v);
    data_valid[k] = 1'b1; data_in[k] = v;
    tick();
    data_valid[k] = 1'b0;
  endtask

  task do_reset();
    reset = 1'b1; out_ready = 1'b1; data_valid = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk(nm, out_valid, 1);
  endtask

  task wait_done(input string nm);
    int n = 0;
    while (!frame_done && n < 80) begin tick(); n++; end
    chk(nm, frame_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, pulses;
    tick(); tick();
    // reset state
    chk("rst_valid", out_valid, 0);   chk("rst_data", out_data, 0);
    chk("rst_kernel", out_kernel, 0); chk("rst_addr", out_addr, 0);
    chk("rst_done", frame_done, 0);   chk("rst_ovf", overflow, 0);
    chk("rst_hold", hold, 0);         chk("rst_stall", stall, 0);
    reset = 1'b0;

    // 1: kernels 0..3 on consecutive cycles, one-cycle latency, back-to-back
    push(0, 10); chk("t1_lat0", out_valid, 0);
    push(1, 11); chk("t1_lat1", out_valid, 1); chk("t1_d0", out_data, 10); chk("t1_k0", out_kernel, 0);
    push(2, 12); chk("t1_d1", out_data, 11); chk("t1_k1", out_kernel, 1);
    push(3, 13); chk("t1_d2", out_data, 12);
    tick();      chk("t1_d3", out_data, 13); chk("t1_k3", out_kernel, 3); chk("t1_a", out_addr, 0);
    tick();      chk("t1_idle", out_valid, 0);

    // 2: strict order, kernel 1 waits for kernel 0
    do_reset();
    push(1, 7);
    repeat (3) begin tick(); chk("t2_wait", out_valid, 0); end
    push(0, 5);
    tick(); chk("t2_v", out_valid, 1); chk("t2_d0", out_data, 5); chk("t2_k0", out_kernel, 0);
    tick(); chk("t2_d1", out_data, 7); chk("t2_k1", out_kernel, 1);

    // 3: full frame, single frame_done, next frame restarts at k0/addr0
    do_reset();
    for (int i = 0; i < 16; i++) push(i % NK, 100 + i);
    pulses = 0;
    repeat (12) begin if (frame_done) pulses++; tick(); end
    chk("t3_pulses", pulses, 1);
    push(0, 55);
    tick(); chk("t3_v", out_valid, 1); chk("t3_d", out_data, 55);
    chk("t3_k", out_kernel, 0); chk("t3_a", out_addr, 0);

    // 4: hold and overflow on kernel 2 with kernel 0 empty
    do_reset();
    out_ready = 1'b0;
    push(2, 1); push(2, 2); chk("t4_hold2", hold, 4'b0000);
    push(2, 3); chk("t4_hold3", hold, 4'b0100);
    push(2, 4); push(2, 5);
    chk("t4_ovf", overflow, 1); chk("t4_valid", out_valid, 0); chk("t4_data", out_data, 0);
    out_ready = 1'b1;

    // 5: reset mid-frame after 6 accepts
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(i % NK, 200 + i);
    out_ready = 1'b1;
    n = 0; g = 0;
    while (n < 6 && g < 50) begin if (out_valid) n++; tick(); g++; end
    chk("t5_accepts", n, 6);
    reset = 1'b1; #1;
    chk("t5_valid", out_valid, 0); chk("t5_data", out_data, 0);
    chk("t5_k", out_kernel, 0);    chk("t5_a", out_addr, 0);
    chk("t5_hold", hold, 0);       chk("t5_done", frame_done, 0);
    tick(); reset = 1'b0;
    push(0, 77);
    tick(); chk("t5_v2", out_valid, 1); chk("t5_d2", out_data, 77);
    chk("t5_k2", out_kernel, 0); chk("t5_a2", out_addr, 0);

    // 6: stall counter (5 stalled cycles, cleared after frame_done)
    do_reset();
    out_ready = 1'b0;
    push(0, 300);
    wait_valid("t6_valid_timeout");
    repeat (5) tick();
    chk("t6_stall5", stall, STALL5);
    chk("t6_held", out_data, 300);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) push(i % NK, 300 + i);
    wait_done("t6_done_timeout");
    chk("t6_stall_pre", stall, STALL5);
    tick(); chk("t6_stall_clr", stall, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
